// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit that owns the HI/LO registers.
//   A MULT/MULTU op runs a shift-add multiply, one bit per cycle.
//   A DIV/DIVU op runs a restoring divide, one bit per cycle.
//   MTHI/MTLO write Hi/Lo directly in IDLE and complete in that cycle.
//
// Handshake: an op is accepted when Start=1 and Flush=0 at a clk edge while
// the FSM is IDLE (Busy=0). Start is ignored while Busy=1; it is not queued.
// Done pulses for one cycle when a MULT/DIV result lands in Hi/Lo.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - synchronous active-low reset
//   Start     - request, qualified by Funct/SrcA/SrcB
//   Funct     - R-type funct code (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   SrcA      - rs operand (multiplicand / dividend / MTxx data)
//   SrcB      - rt operand (multiplier / divisor)
//   Flush     - abort an in-flight op
//   Busy      - op in progress
//   Done      - one-cycle completion pulse for MULT/DIV
//   DivByZero - sticky divide-by-zero flag, cleared by the next accepted op
//   Hi, Lo    - HI/LO registers
//
// Configuration macro: MDU_EARLY_TERM_EN enables early termination of
// multiplies once the remaining multiplier bits are all zero.
// The FSM state is visible as the internal signal 'state'.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  // Multiply: acc is the running product, mcand the pre-shifted multiplicand.
  // Divide:   acc = {remainder, quotient/dividend}, mcand[WIDTH-1:0] = divisor.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               dbz_op;

  // Decode of the incoming request.
  logic             op_mdu, op_div, op_signed;
  logic [WIDTH-1:0] abs_a, abs_b;

  always_comb begin
    op_mdu    = (Funct == F_MULT) || (Funct == F_MULTU) ||
                (Funct == F_DIV)  || (Funct == F_DIVU);
    op_div    = (Funct == F_DIV)  || (Funct == F_DIVU);
    op_signed = (Funct == F_MULT) || (Funct == F_DIV);
    // Magnitude of the most-negative value fits as an unsigned WIDTH-bit number.
    abs_a     = (op_signed && SrcA[WIDTH-1]) ? -SrcA : SrcA;
    abs_b     = (op_signed && SrcB[WIDTH-1]) ? -SrcB : SrcB;
  end

  // One restoring-divide step: shift in the next dividend bit, trial subtract.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_next;

  always_comb begin
    div_shift    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff     = div_shift - {1'b0, mcand[WIDTH-1:0]};
    div_ge       = (div_shift >= {1'b0, mcand[WIDTH-1:0]});
    div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  end

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Because the multiplicand is shifted into place every step, the product
  // is already final once no set multiplier bits remain after this step.
  logic early_done;
`ifdef MDU_EARLY_TERM_EN
  assign early_done = !is_div && (mplier[WIDTH-1:1] == '0);
`else
  assign early_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      is_div    <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      dbz_op    <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start && !Flush) begin
            if (op_mdu) begin
              DivByZero <= 1'b0;
              Busy      <= 1'b1;
              count     <= CNT_W'(WIDTH - 1);
              is_div    <= op_div;
              neg_res   <= op_signed && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
              neg_rem   <= (Funct == F_DIV) && SrcA[WIDTH-1];
              dbz_op    <= 1'b0;
              mplier    <= abs_b;
              if (op_div) begin
                if (SrcB == '0) begin
                  // Result is fixed: Hi=dividend, Lo=all ones; skip RUN.
                  dbz_op <= 1'b1;
                  acc    <= {SrcA, {WIDTH{1'b1}}};
                  mcand  <= '0;
                  state  <= FIX;
                end else begin
                  acc   <= {{WIDTH{1'b0}}, abs_a};
                  mcand <= {{WIDTH{1'b0}}, abs_b};
                  state <= RUN;
                end
              end else begin
                acc   <= '0;
                mcand <= {{WIDTH{1'b0}}, abs_a};
                state <= RUN;
              end
            end else if (Funct == F_MTHI) begin
              Hi <= SrcA;
            end else if (Funct == F_MTLO) begin
              Lo <= SrcA;
            end
          end
        end

        RUN: begin
          if (Flush) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else begin
            if (is_div) begin
              acc <= {div_rem_next, acc[WIDTH-2:0], div_ge};
            end else begin
              acc    <= acc + (mplier[0] ? mcand : '0);
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
            end
            if (count == '0 || early_done) begin
              count <= '0;
              state <= FIX;
            end else begin
              count <= count - 1'b1;
            end
          end
        end

        FIX: begin
          state <= IDLE;
          Busy  <= 1'b0;
          if (!Flush) begin
            Done <= 1'b1;
            if (dbz_op) begin
              Hi        <= acc[2*WIDTH-1:WIDTH];
              Lo        <= acc[WIDTH-1:0];
              DivByZero <= 1'b1;
            end else if (is_div) begin
              Hi <= rem_fix;
              Lo <= quo_fix;
            end else begin
              Hi <= prod_fix[2*WIDTH-1:WIDTH];
              Lo <= prod_fix[WIDTH-1:0];
            end
          end
        end

        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed test of mdu_iter at WIDTH=32.
// Inputs are driven 1ns after the rising edge; outputs are sampled at the
// same point, so every check observes the state settled by the last edge.
module tb_mdu_iter;

  localparam int W = 32;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         Start;
  logic [5:0]   Funct;
  logic [W-1:0] SrcA, SrcB;
  logic         Flush;
  logic         Busy, Done, DivByZero;
  logic [W-1:0] Hi, Lo;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start     (Start),
    .Funct     (Funct),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Flush     (Flush),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero),
    .Hi        (Hi),
    .Lo        (Lo)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic saw_done, saw_busy;
  int lat, bcyc;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (Done === 1'b1) saw_done = 1'b1;
      if (Busy === 1'b1) saw_busy = 1'b1;
    end
  endtask

  // One-cycle Start pulse; returns just after the accepting edge.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    Start = 1'b1;
    Funct = f;
    SrcA  = a;
    SrcB  = b;
    tick();
    Start = 1'b0;
    Funct = 6'b000000;
  endtask

  // Counts edges from acceptance until Done, and cycles with Busy high.
  task automatic wait_done(output int l, output int bc);
    l  = 0;
    bc = (Busy === 1'b1) ? 1 : 0;
    while (Done !== 1'b1 && l < 100) begin
      tick();
      l++;
      if (Busy === 1'b1) bc++;
    end
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; Start = 1'b0; Flush = 1'b0;
    Funct = 6'b000000; SrcA = '0; SrcB = '0;
    tick_n(3);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_dbz",  64'(DivByZero), 64'd0);
    chk("rst_hi",   64'(Hi), 64'd0);
    chk("rst_lo",   64'(Lo), 64'd0);
    rst_n = 1'b1;
    tick();

    // MULTU FFFFFFFF * 2
    issue(F_MULTU, 32'hFFFFFFFF, 32'h00000002);
    chk("multu_busy_after_e", 64'(Busy), 64'd1);
    wait_done(lat, bcyc);
    chk("multu_latency", 64'(lat), 64'd33);
    chk("multu_busy_cycles", 64'(bcyc), 64'd33);
    chk("multu_hi", 64'(Hi), 64'h00000001);
    chk("multu_lo", 64'(Lo), 64'hFFFFFFFE);
    chk("multu_dbz", 64'(DivByZero), 64'd0);
    tick();
    chk("multu_done_pulse", 64'(Done), 64'd0);

    // MULT -7 * 3 = -21
    issue(F_MULT, 32'hFFFFFFF9, 32'h00000003);
    wait_done(lat, bcyc);
    chk("mult_latency", 64'(lat), 64'd33);
    chk("mult_hi", 64'(Hi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(Lo), 64'hFFFFFFEB);

    // DIV -17 / 5 = -3 rem -2
    issue(F_DIV, 32'hFFFFFFEF, 32'h00000005);
    wait_done(lat, bcyc);
    chk("div_latency", 64'(lat), 64'd33);
    chk("div_lo", 64'(Lo), 64'hFFFFFFFD);
    chk("div_hi", 64'(Hi), 64'hFFFFFFFE);

    // DIV most-negative / -1 wraps
    issue(F_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, bcyc);
    chk("divwrap_lo", 64'(Lo), 64'h80000000);
    chk("divwrap_hi", 64'(Hi), 64'h00000000);
    chk("divwrap_dbz", 64'(DivByZero), 64'd0);

    // DIVU FFFFFFFF / 16
    issue(F_DIVU, 32'hFFFFFFFF, 32'h00000010);
    wait_done(lat, bcyc);
    chk("divu_lo", 64'(Lo), 64'h0FFFFFFF);
    chk("divu_hi", 64'(Hi), 64'h0000000F);

    // DIVU 100 / 0
    issue(F_DIVU, 32'd100, 32'd0);
    wait_done(lat, bcyc);
    chk("dbz_latency", 64'(lat), 64'd1);
    chk("dbz_busy_cycles", 64'(bcyc), 64'd1);
    chk("dbz_flag", 64'(DivByZero), 64'd1);
    chk("dbz_hi", 64'(Hi), 64'd100);
    chk("dbz_lo", 64'(Lo), 64'hFFFFFFFF);
    tick();
    chk("dbz_sticky", 64'(DivByZero), 64'd1);
    chk("dbz_done_pulse", 64'(Done), 64'd0);

    // MULTU 6*7, ignored DIVU at E+5, Flush seen at E+11
    saw_done = 1'b0;
    issue(F_MULTU, 32'd6, 32'd7);
    chk("dbz_cleared_on_start", 64'(DivByZero), 64'd0);
    tick_n(4);
    issue(F_DIVU, 32'd9, 32'd3);
    tick_n(5);
    Flush = 1'b1;
    tick_n(1);
    Flush = 1'b0;
    chk("flush_busy", 64'(Busy), 64'd0);
    chk("flush_hi", 64'(Hi), 64'd100);
    chk("flush_lo", 64'(Lo), 64'hFFFFFFFF);
    saw_busy = 1'b0;
    tick_n(40);
    chk("flush_no_done", 64'(saw_done), 64'd0);
    chk("flush_stays_idle", 64'(saw_busy), 64'd0);
    issue(F_MTLO, 32'h00001234, 32'd0);
    chk("mtlo_lo", 64'(Lo), 64'h00001234);
    chk("mtlo_hi", 64'(Hi), 64'd100);
    chk("mtlo_busy", 64'(Busy), 64'd0);
    chk("mtlo_done", 64'(Done), 64'd0);

    // MTHI and an unknown funct
    issue(F_MTHI, 32'h0000ABCD, 32'd0);
    chk("mthi_hi", 64'(Hi), 64'h0000ABCD);
    chk("mthi_busy", 64'(Busy), 64'd0);
    issue(6'b100000, 32'd5, 32'd5);
    chk("unknown_hi", 64'(Hi), 64'h0000ABCD);
    chk("unknown_lo", 64'(Lo), 64'h00001234);
    chk("unknown_busy", 64'(Busy), 64'd0);

    // Start together with Flush in IDLE
    saw_done = 1'b0;
    Flush = 1'b1;
    issue(F_MULTU, 32'd2, 32'd2);
    Flush = 1'b0;
    chk("startflush_busy", 64'(Busy), 64'd0);
    tick_n(40);
    chk("startflush_no_done", 64'(saw_done), 64'd0);
    chk("startflush_lo", 64'(Lo), 64'h00001234);

    // Start while Busy is ignored
    issue(F_MULTU, 32'd3, 32'd4);
    tick_n(3);
    issue(F_DIVU, 32'd9, 32'd3);
    wait_done(lat, bcyc);
    chk("busy_start_latency", 64'(lat + 4), 64'd33);
    chk("busy_start_lo", 64'(Lo), 64'd12);
    chk("busy_start_hi", 64'(Hi), 64'd0);

    // Reset in the middle of a DIV
    saw_done = 1'b0;
    issue(F_DIV, 32'd1000, 32'd7);
    tick_n(10);
    rst_n = 1'b0;
    tick_n(1);
    chk("midrst_busy", 64'(Busy), 64'd0);
    chk("midrst_hi", 64'(Hi), 64'd0);
    chk("midrst_lo", 64'(Lo), 64'd0);
    rst_n = 1'b1;
    tick_n(40);
    chk("midrst_no_done", 64'(saw_done), 64'd0);

    // MULTU 5*1: early termination shortens it to two cycles when enabled
    issue(F_MULTU, 32'd5, 32'd1);
    wait_done(lat, bcyc);
`ifdef MDU_EARLY_TERM_EN
    chk("mul5x1_latency", 64'(lat), 64'd2);
`else
    chk("mul5x1_latency", 64'(lat), 64'd33);
`endif
    chk("mul5x1_lo", 64'(Lo), 64'd5);
    chk("mul5x1_hi", 64'(Hi), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit for the MIPS pipeline EX stage. Owns the HI/LO registers.
- Decodes R-type Funct for MULT, MULTU, DIV, DIVU, MTHI and MTLO, computes over multiple cycles, and signals Busy so the hazard unit stalls MFHI/MFLO and any new MDU op.
- Generalises the combinational ALU decode path with width parametrisation, multi-cycle sequencing and a handshake.

Parameters:
- WIDTH, 32, operand/HI/LO width; legal values 8..64, even.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- Start  input  1  request, valid with Funct/SrcA/SrcB
- Funct  input  6  011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO; other codes ignored
- SrcA  input  WIDTH  rs operand (multiplicand/dividend/MTxx data)
- SrcB  input  WIDTH  rt operand (multiplier/divisor)
- Flush  input  1  abort in-flight op (branch/exception squash)
- Busy  output  1  op in progress; Start ignored while high
- Done  output  1  one-cycle pulse when HI/LO updated by MULT/DIV
- DivByZero  output  1  sticky flag; set on div with SrcB==0, cleared by next accepted Start
- Hi  output  WIDTH  HI register
- Lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n==0 at a clk edge):
  - State=IDLE; Busy=0, Done=0, DivByZero=0, Hi=0, Lo=0, counter=0.
  - Reset overrides Start and Flush, and aborts any op.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - Start=1 with MULT/MULTU/DIV/DIVU (Flush=0) is accepted.
    - Latch operands. Signed ops store absolute values plus result-sign bits.
    - Clear DivByZero, counter=WIDTH-1, go to RUN.
    - Busy=1 from the next cycle.
  - MTHI/MTLO: write Hi/Lo at the same edge. Stay IDLE; no Busy, no Done.
  - Unknown Funct: no effect.
- RUN:
  - One iteration per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - When counter==0, go to FIX; otherwise counter decrements.
  - Exactly WIDTH RUN cycles.
- FIX:
  - Apply two's-complement sign correction.
    - Product negated if signs differ.
    - Quotient negated if signs differ.
    - Remainder takes the dividend's sign.
  - Write Hi/Lo: multiply Hi=upper WIDTH, Lo=lower WIDTH; divide Lo=quotient, Hi=remainder.
  - Done=1 for that cycle, Busy=0, go to IDLE.
- Latency: Start accepted at edge E. Hi/Lo valid and Done=1 after edge E+WIDTH+1. Busy=1 for exactly WIDTH+1 cycles.
- Divide by zero (DIV/DIVU, SrcB==0):
  - Accepted, RUN skipped, goes directly to FIX.
  - Hi=SrcA, Lo=all ones, DivByZero=1, Done pulses at edge E+1.
- Signed DIV of most-negative by -1: Lo=most-negative (wrap), Hi=0, no flag.
- Start while Busy=1: ignored entirely. Operands and Funct are not queued.
- Flush:
  - While RUN or FIX: next edge returns to IDLE, Busy=0, no Done, Hi/Lo unchanged.
  - Flush and Start together in IDLE: Start ignored.
- Done is never asserted for MTHI/MTLO or flushed ops. Hi/Lo change only at FIX, MTxx, or reset.

Optional Feature:
- Macro MDU_EARLY_TERM_EN.
- Defined:
  - In RUN for MULT/MULTU, if the remaining unshifted multiplier bits are all zero, go to FIX at the next edge. The partial product is pre-aligned so the result is identical.
  - Latency becomes variable, minimum 2 cycles (SrcB==0 or 1).
  - Divide latency is unchanged.
- Undefined: fixed WIDTH+1 latency for all non-zero-divisor ops. Early-termination logic is absent.

Test Plan:
- Reset, then MULTU SrcA=32'hFFFFFFFF, SrcB=32'h00000002:
  - Busy high 33 cycles, Done at E+33.
  - Hi=32'h00000001, Lo=32'hFFFFFFFE.
- MULT SrcA=-7 (32'hFFFFFFF9), SrcB=3: Hi=32'hFFFFFFFF, Lo=32'hFFFFFFEB (-21).
- DIV SrcA=-17, SrcB=5: Lo=32'hFFFFFFFD (-3), Hi=32'hFFFFFFFE (-2).
- DIVU SrcA=100, SrcB=0:
  - Done at E+1, DivByZero=1, Hi=100, Lo=32'hFFFFFFFF.
  - Next accepted Start clears DivByZero.
- MULTU 6x7 started, second Start (DIVU 9/3) issued at E+5, Flush asserted at E+10:
  - Second Start ignored.
  - Busy drops after E+11, no Done, Hi/Lo keep prior values.
  - A following MTLO 32'h1234 sets Lo=32'h1234 with Busy=0.
- rst_n=0 mid-RUN (E+10) of DIV: next edge Busy=0, Hi=Lo=0, Done never pulses. With MDU_EARLY_TERM_EN, MULTU 5x1 pulses Done at E+2 with Lo=5.
